// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if -- valid/ready handshake bundle for one pipeline stage.
// The master modport is the side that offers payloads upstream and consumes
// them downstream; the slave modport is the stage itself.
interface pipe_stage_skid_if #(
    parameter int unsigned WIDTH = 32
);
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] InData;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] OutData;

    modport master (
        output InValid,
        output InData,
        output OutReady,
        input  InReady,
        input  OutValid,
        input  OutData
    );

    modport slave (
        input  InValid,
        input  InData,
        input  OutReady,
        output InReady,
        output OutValid,
        output OutData
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid -- two-entry skid pipeline stage (main + skid register).
// InReady is registered so OutReady never reaches it combinationally; the
// skid register absorbs the one payload that can arrive while a stall is
// being signalled upstream.
// Optional macro PIPE_STAGE_SKID_PERF_EN adds saturating StallCount and
// FlushCount outputs. WIDTH must match the WIDTH of the connected interface.
module pipe_stage_skid #(
    parameter int unsigned         WIDTH        = 32,
    parameter logic [WIDTH-1:0]    BUBBLE_VALUE = '0
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Flush,
    pipe_stage_skid_if.slave       bus,
    output logic [1:0]             Occupancy
`ifdef PIPE_STAGE_SKID_PERF_EN
    ,
    output logic [15:0]            StallCount,
    output logic [15:0]            FlushCount
`endif
);

    // Held-payload states; the state alone carries both valid bits, which
    // makes "skid valid without main valid" unrepresentable.
    typedef enum logic [1:0] {
        stEmpty = 2'd0,
        stMain  = 2'd1,
        stFull  = 2'd2
    } stageState_t;

    stageState_t      stateQ, stateD;
    logic [WIDTH-1:0] mainDataQ, mainDataD;
    logic [WIDTH-1:0] skidDataQ, skidDataD;
    logic             inReadyQ;
    logic             mainValid;
    logic             skidValid;
    logic             accept;
    logic             emit;

    assign mainValid = (stateQ != stEmpty);
    assign skidValid = (stateQ == stFull);
    assign accept    = bus.InValid && inReadyQ;
    assign emit      = mainValid && bus.OutReady;

    assign bus.InReady  = inReadyQ;
    assign bus.OutValid = mainValid;
    assign bus.OutData  = mainDataQ;
    assign Occupancy    = {1'b0, mainValid} + {1'b0, skidValid};

    // Next-state and data-path steering; flush discards everything held and offered.
    always_comb begin
        stateD    = stateQ;
        mainDataD = mainDataQ;
        skidDataD = skidDataQ;
        if (Flush) begin
            stateD    = stEmpty;
            mainDataD = BUBBLE_VALUE;
            skidDataD = BUBBLE_VALUE;
        end else begin
            case (stateQ)
                stEmpty: begin
                    if (accept) begin
                        stateD    = stMain;
                        mainDataD = bus.InData;
                    end
                end
                stMain: begin
                    if (accept && emit) begin
                        mainDataD = bus.InData;
                    end else if (accept) begin
                        stateD    = stFull;
                        skidDataD = bus.InData;
                    end else if (emit) begin
                        stateD = stEmpty;
                    end
                end
                stFull: begin
                    // InReady is low here, so only an emit can occur.
                    if (emit) begin
                        stateD    = stMain;
                        mainDataD = skidDataQ;
                        skidDataD = BUBBLE_VALUE;
                    end
                end
                default: begin
                    stateD = stEmpty;
                end
            endcase
        end
    end

    // State and payload registers; InReady is registered from the next state.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            stateQ    <= stEmpty;
            mainDataQ <= BUBBLE_VALUE;
            skidDataQ <= BUBBLE_VALUE;
            inReadyQ  <= 1'b1;
        end else begin
            stateQ    <= stateD;
            mainDataQ <= mainDataD;
            skidDataQ <= skidDataD;
            inReadyQ  <= (stateD != stFull);
        end
    end

`ifdef PIPE_STAGE_SKID_PERF_EN
    // Saturating stall and flush event counters.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (mainValid && !bus.OutReady && (StallCount != '1)) begin
                StallCount <= StallCount + 16'd1;
            end
            if (Flush && (FlushCount != '1)) begin
                FlushCount <= FlushCount + 16'd1;
            end
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the payload bit width.
REQ-002 Parameter BUBBLE_VALUE, default 0, SHALL set the WIDTH-bit payload driven on OutData after reset or flush.
REQ-003 Clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 Flush  input  1  SHALL be a synchronous stage flush from hazard/branch logic.
REQ-006 InValid  input  1  SHALL mark that InData holds a payload offered by the upstream stage.
REQ-007 InReady  output  1  SHALL mark that the stage can accept a payload this cycle.
REQ-008 InData  input  WIDTH  SHALL carry the upstream payload.
REQ-009 OutValid  output  1  SHALL mark that OutData holds a payload for the downstream stage.
REQ-010 OutReady  input  1  SHALL mark that downstream consumes OutData this cycle; low means stall.
REQ-011 OutData  output  WIDTH  SHALL carry the oldest held payload.
REQ-012 Occupancy  output  2  SHALL report the number of held payloads (0..2).

Function
REQ-013 Storage SHALL be a main register (feeds OutData) plus one skid register, each with a valid bit.
REQ-014 Accept SHALL occur iff InValid && InReady; emit SHALL occur iff OutValid && OutReady.
REQ-015 InReady SHALL be a registered signal equal to !SkidValid, with no combinational path from OutReady.
REQ-016 OutValid SHALL equal MainValid; OutData SHALL equal the main register.
REQ-017 Accept, empty stage: payload SHALL enter the main register; OutValid SHALL be high the next cycle (latency 1).
REQ-018 Accept with main full, no emit: payload SHALL enter the skid register; InReady SHALL go low the next cycle.
REQ-019 Accept and emit in the same cycle, skid empty: payload SHALL replace the main register (throughput 1/cycle).
REQ-020 Emit with skid full: skid payload SHALL move to the main register; skid SHALL become empty; InReady SHALL go high the next cycle.
REQ-021 While OutValid && !OutReady, OutData SHALL remain stable.
REQ-022 Payloads SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-023 Flush SHALL clear both valid bits, set both registers to BUBBLE_VALUE, and drive InReady high the next cycle.
REQ-024 Flush SHALL override an accept or emit in the same cycle; the offered payload SHALL be discarded.
REQ-025 Occupancy SHALL equal MainValid + SkidValid after every edge.
REQ-026 SkidValid && !MainValid SHALL be unreachable.

Reset
REQ-027 Reset SHALL take priority over Flush and all handshakes.
REQ-028 On reset: OutValid=0, InReady=1, Occupancy=0, OutData=BUBBLE_VALUE, skid register=BUBBLE_VALUE.
REQ-029 Reset asserted mid-stall SHALL discard both held payloads; the first accept after deassertion SHALL behave as if the stage were empty.

Configuration
REQ-030 Macro PIPE_STAGE_SKID_PERF_EN defined: outputs StallCount[15:0] and FlushCount[15:0] SHALL exist.
REQ-031 StallCount SHALL increment each cycle with OutValid && !OutReady; FlushCount SHALL increment each cycle with Flush.
REQ-032 Both counters SHALL saturate at 16'hFFFF and clear on Reset.
REQ-033 Macro undefined: neither counter port nor counter logic SHALL exist; all other behaviour SHALL be identical.

Verification
REQ-034 Reset, then InValid=1, InData=32'h11, OutReady=1 -> OutValid=1, OutData=32'h11 one cycle later; Occupancy=1.
REQ-035 Stream 32'h1..32'h8 back-to-back, OutReady=1 -> eight outputs on consecutive cycles, in order, InReady constantly 1.
REQ-036 OutReady=0, offer 32'hA then 32'hB -> Occupancy=2, InReady=0, OutData=32'hA held; OutReady=1 -> emits A then B, InReady=1 after A emits.
REQ-037 Occupancy=2 and Flush=1 with InValid=1, InData=32'hC -> next cycle OutValid=0, Occupancy=0, OutData=BUBBLE_VALUE, InReady=1; 32'hC never emitted.
REQ-038 Reset=1 and Flush=1 together while Occupancy=2 -> reset values of REQ-028; with PERF_EN, FlushCount=0.
REQ-039 PERF_EN, OutValid=1, OutReady=0 for 70000 cycles -> StallCount=16'hFFFF and held.
